branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters.
- Next-generation replacement for the fixed "resolve in D, flush on taken" branch scheme of the 5-stage pipeline.
- Looked up with the F-stage pc in the same cycle; trained by the D-stage branch resolution (branch & equalD, pc_branch).
- The datapath uses pred_taken/pred_target to steer pc_next. On a mispredict it applies its existing F/D flush.

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Optional macro BP_STATS_EN adds stat_branches/stat_mispreds counters.
module branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clka,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispred,
  input  logic            tbl_clear
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispreds
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [PC_W-1:0]  PC_STEP   = {{(PC_W-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_WEAKN = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_WEAKT = {1'b1, {(CNT_W-1){1'b0}}};

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [PC_W-1:0]  target_r [ENTRIES];
  logic [CNT_W-1:0] cnt_r    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic             unused_s;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic taken);
    logic [CNT_W-1:0] nxt;
    if (taken) begin
      nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end else begin
      nxt = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
    end
    return nxt;
  endfunction

  assign lk_idx_s  = lookup_pc[IDX_W+1:2];
  assign lk_tag_s  = lookup_pc[PC_W-1:IDX_W+2];
  assign upd_idx_s = upd_pc[IDX_W+1:2];
  assign upd_tag_s = upd_pc[PC_W-1:IDX_W+2];
  assign unused_s  = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispred};

  // Zero-latency lookup; reads pre-update contents when an update targets the same index.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lookup_pc + PC_STEP;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      pred_hit   = 1'b1;
      pred_taken = cnt_r[lk_idx_s][CNT_W-1];
    end else begin
      pred_hit   = 1'b0;
      pred_taken = 1'b0;
    end
    if (pred_taken) begin
      pred_target = target_r[lk_idx_s];
    end else begin
      pred_target = lookup_pc + PC_STEP;
    end
  end

  // Tag match for the resolving branch.
  always_comb begin
    upd_hit_s = 1'b0;
    if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
      upd_hit_s = 1'b1;
    end else begin
      upd_hit_s = 1'b0;
    end
  end

  // Table training; tbl_clear takes priority over any update in the same cycle.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {PC_W{1'b0}};
        cnt_r[i]    <= CNT_WEAKN;
      end
    end else if (tbl_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        cnt_r[upd_idx_s] <= cnt_next(cnt_r[upd_idx_s], upd_taken);
        if (upd_taken) begin
          target_r[upd_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target;
        cnt_r[upd_idx_s]    <= CNT_WEAKT;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating resolution statistics, untouched by tbl_clear.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      stat_branches <= 32'd0;
      stat_mispreds <= 32'd0;
    end else begin
      if (upd_valid && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (upd_valid && upd_mispred && (stat_mispreds != 32'hFFFF_FFFF)) begin
        stat_mispreds <= stat_mispreds + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

  logic        clka;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        tbl_clear;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispreds;
`endif

  int checks = 0;
  int failures = 0;

  branch_predictor #(.PC_W(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clka(clka),
    .rst(rst),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_mispred(upd_mispred),
    .tbl_clear(tbl_clear)
`ifdef BP_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispreds(stat_mispreds)
`endif
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mp);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_mispred = mp;
    tick();
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    lookup_pc = 32'h0000_0040;
    upd_valid = 1'b0;
    upd_pc = 32'd0;
    upd_taken = 1'b0;
    upd_target = 32'd0;
    upd_mispred = 1'b0;
    tbl_clear = 1'b0;
    #2;
    look("in_reset", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    #20;
    rst = 1'b1;
    tick();

    // 1: empty table, pc+4 with wrap
    look("t1_miss", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    look("t1_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // 2: allocate 0x40
    upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    look("t2_alloc", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100);

    // 3: counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10
    upd(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0);
    look("t3_nt1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    upd(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0);
    upd(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0);
    look("t3_nt3", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    look("t3_tk1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    look("t3_tk2", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100);

    // 4: alias 0x80 evicts 0x40; not-taken miss leaves table alone
    upd(32'h0000_0080, 1'b1, 32'h0000_0200, 1'b0);
    look("t4_evicted", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    look("t4_alias", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0200);
    upd(32'h0000_00C0, 1'b0, 32'h0000_0777, 1'b0);
    look("t4_nt_miss", 32'h0000_00C0, 1'b0, 1'b0, 32'h0000_00C4);
    look("t4_kept", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0200);

    // 5a: same-cycle update and lookup returns old contents
    upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_0040;
    upd_taken  = 1'b1;
    upd_target = 32'h0000_0300;
    look("t5_same_cycle", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100);
    tick();
    upd_valid = 1'b0;
    look("t5_next_cycle", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0300);

    // counter saturates at 11; a single not-taken keeps it taken and target unchanged
    upd(32'h0000_0040, 1'b1, 32'h0000_0300, 1'b0);
    upd(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0);
    look("t5_sat_hi", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0300);

    // 5b: clear wins over simultaneous allocate
    tbl_clear = 1'b1;
    upd(32'h0000_0080, 1'b1, 32'h0000_0200, 1'b0);
    tbl_clear = 1'b0;
    look("t5_clr_40", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    look("t5_clr_80", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);

    // 5c: asynchronous reset mid-cycle, also holding off an update
    upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    look("t5_pre_rst", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100);
    #1;
    rst = 1'b0;
    look("t5_rst_async", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    upd(32'h0000_0080, 1'b1, 32'h0000_0200, 1'b1);
    look("t5_rst_hold", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);
    #2;
    rst = 1'b1;
    tick();
    look("t5_after_rst", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);

`ifdef BP_STATS_EN
    // 6: statistics
    chk("t6_br_zero", stat_branches, 32'd0);
    chk("t6_mp_zero", stat_mispreds, 32'd0);
    upd(32'h0000_0010, 1'b1, 32'h0000_0400, 1'b0);
    upd(32'h0000_0010, 1'b0, 32'h0000_0400, 1'b1);
    tbl_clear = 1'b1;
    upd(32'h0000_0020, 1'b0, 32'h0000_0400, 1'b0);
    tbl_clear = 1'b0;
    chk("t6_branches", stat_branches, 32'd3);
    chk("t6_mispreds", stat_mispreds, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_br_rst", stat_branches, 32'd0);
    chk("t6_mp_rst", stat_mispreds, 32'd0);
    rst = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
